// File: rtl/drums_pkg.sv
// Shared constants, colour table and helpers for the Drums Hero note highway.
package drums_pkg;

    localparam int unsigned N_LANES_D = 5;
    localparam int unsigned N_ROWS_D  = 8;
    localparam int unsigned Y_W_D     = 10;
    localparam int unsigned SPEED_D   = 1;
    localparam int unsigned X0_D      = 80;
    localparam int unsigned PITCH_D   = 96;
    localparam int unsigned LANE_W_D  = 64;
    localparam int unsigned END_Y_D   = 480;
    localparam int unsigned HIT_LO_D  = 400;
    localparam int unsigned HIT_HI_D  = 440;

    localparam logic [7:0] FONDO = 8'd255;

    typedef enum logic [1:0] {
        JUDGE_IDLE,
        JUDGE_EMPTY,
        JUDGE_OUTSIDE,
        JUDGE_WINDOW
    } judge_e;

    function automatic logic [7:0] lane_color(input int unsigned lane);
        case (lane % 5)
            0:       lane_color = 8'd224;
            1:       lane_color = 8'd28;
            2:       lane_color = 8'd252;
            3:       lane_color = 8'd3;
            default: lane_color = 8'd248;
        endcase
    endfunction

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((32'd1 << result) < value) result++;
        return result;
    endfunction

endpackage

// File: rtl/highway_row_fifo.sv
// Ring buffer of falling note rows {y, mask}; every slot is exposed for the render scan.
module highway_row_fifo
    import drums_pkg::*;
#(
    parameter int unsigned N_LANES = N_LANES_D,
    parameter int unsigned N_ROWS  = N_ROWS_D,
    parameter int unsigned Y_W     = Y_W_D,
    parameter int unsigned SPEED   = SPEED_D,
    parameter int unsigned PTR_W   = clog2(N_ROWS)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             i_flush,
    input  logic                             i_push,
    input  logic [N_LANES-1:0]               i_push_mask,
    input  logic                             i_pop,
    input  logic                             i_advance,
    input  logic [N_LANES-1:0]               i_clr_bits,
    output logic [PTR_W:0]                   o_count,
    output logic                             o_empty,
    output logic [Y_W-1:0]                   o_head_y,
    output logic [N_LANES-1:0]               o_head_mask,
    output logic [N_ROWS-1:0][Y_W-1:0]       o_ys,
    output logic [N_ROWS-1:0][N_LANES-1:0]   o_masks,
    output logic [N_ROWS-1:0]                o_valid
);

    logic [PTR_W-1:0]                 r_head;
    logic [PTR_W-1:0]                 r_tail;
    logic [PTR_W:0]                   r_count;
    logic [N_ROWS-1:0][Y_W-1:0]       r_ys;
    logic [N_ROWS-1:0][N_LANES-1:0]   r_masks;
    logic [N_ROWS-1:0]                w_valid;

    // A slot is occupied when its distance from the head is below the count.
    always_comb begin
        w_valid = '0;
        for (int unsigned i = 0; i < N_ROWS; i++) begin
            w_valid[i] = ({1'b0, PTR_W'(i) - r_head} < r_count);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_ys    <= '0;
            r_masks <= '0;
        end else if (i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_ys    <= '0;
            r_masks <= '0;
        end else begin
            if (i_advance) begin
                for (int unsigned i = 0; i < N_ROWS; i++) begin
                    if (w_valid[i]) r_ys[i] <= r_ys[i] + Y_W'(SPEED);
                end
            end
            if (r_count != '0) begin
                r_masks[r_head] <= r_masks[r_head] & ~i_clr_bits;
            end
            // Push never lands on the head slot: the parent only pushes when not full.
            if (i_push) begin
                r_ys[r_tail]    <= '0;
                r_masks[r_tail] <= i_push_mask;
                r_tail          <= r_tail + 1'b1;
            end
            if (i_pop) begin
                r_head <= r_head + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_count     = r_count;
    assign o_empty     = (r_count == '0);
    assign o_head_y    = r_ys[r_head];
    assign o_head_mask = r_masks[r_head];
    assign o_ys        = r_ys;
    assign o_masks     = r_masks;
    assign o_valid     = w_valid;

endmodule

// File: rtl/note_highway.sv
// Drums Hero note highway: row buffer, hit judge, retire/miss and per-pixel cube renderer.
module note_highway
    import drums_pkg::*;
#(
    parameter int unsigned N_LANES = N_LANES_D,
    parameter int unsigned N_ROWS  = N_ROWS_D,
    parameter int unsigned Y_W     = Y_W_D,
    parameter int unsigned SPEED   = SPEED_D,
    parameter int unsigned X0      = X0_D,
    parameter int unsigned PITCH   = PITCH_D,
    parameter int unsigned LANE_W  = LANE_W_D,
    parameter int unsigned END_Y   = END_Y_D,
    parameter int unsigned HIT_LO  = HIT_LO_D,
    parameter int unsigned HIT_HI  = HIT_HI_D
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               frame_tick,
    input  logic               row_valid,
    input  logic [N_LANES-1:0] row_mask,
    output logic               row_ready,
    input  logic               hit_strobe,
    input  logic [N_LANES-1:0] hit_lanes,
    output logic [N_LANES-1:0] hit_ok,
    output logic [N_LANES-1:0] hit_bad,
    output logic [N_LANES-1:0] miss,
    input  logic               video_on,
    input  logic [Y_W-1:0]     presentX,
    input  logic [Y_W-1:0]     presentY,
    output logic [7:0]         pixel,
    output logic               pintar
);

    localparam int unsigned PTR_W = clog2(N_ROWS);

    logic [PTR_W:0]                 w_count;
    logic                           w_empty;
    logic [Y_W-1:0]                 w_head_y;
    logic [N_LANES-1:0]             w_head_mask;
    logic [N_ROWS-1:0][Y_W-1:0]     w_ys;
    logic [N_ROWS-1:0][N_LANES-1:0] w_masks;
    logic [N_ROWS-1:0]              w_valid;

    logic                           w_push;
    logic                           w_pop;
    logic [Y_W:0]                   w_tick_head_y;
    logic                           w_in_window;
    judge_e                         w_judge;
    logic [N_LANES-1:0]             w_hit_ok;
    logic [N_LANES-1:0]             w_hit_bad;
    logic [N_LANES-1:0]             w_miss;
    logic                           w_lit;
    logic [7:0]                     w_color;

    logic [N_LANES-1:0]             r_hit_ok;
    logic [N_LANES-1:0]             r_hit_bad;
    logic [N_LANES-1:0]             r_miss;
    logic [7:0]                     r_pixel;
    logic                           r_pintar;

    highway_row_fifo #(
        .N_LANES (N_LANES),
        .N_ROWS  (N_ROWS),
        .Y_W     (Y_W),
        .SPEED   (SPEED),
        .PTR_W   (PTR_W)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_flush     (enable),
        .i_push      (w_push),
        .i_push_mask (row_mask),
        .i_pop       (w_pop),
        .i_advance   (frame_tick),
        .i_clr_bits  (w_hit_ok),
        .o_count     (w_count),
        .o_empty     (w_empty),
        .o_head_y    (w_head_y),
        .o_head_mask (w_head_mask),
        .o_ys        (w_ys),
        .o_masks     (w_masks),
        .o_valid     (w_valid)
    );

    assign row_ready = (w_count < (PTR_W+1)'(N_ROWS));
    assign w_push    = row_valid && row_ready;

    assign w_tick_head_y = {1'b0, w_head_y} + (Y_W+1)'(SPEED);
    assign w_pop         = frame_tick && !w_empty && (w_tick_head_y >= (Y_W+1)'(END_Y));
    assign w_in_window   = (w_head_y >= Y_W'(HIT_LO)) && (w_head_y <= Y_W'(HIT_HI));

    always_comb begin
        if (!hit_strobe)      w_judge = JUDGE_IDLE;
        else if (w_empty)     w_judge = JUDGE_EMPTY;
        else if (w_in_window) w_judge = JUDGE_WINDOW;
        else                  w_judge = JUDGE_OUTSIDE;
    end

    always_comb begin
        w_hit_ok  = '0;
        w_hit_bad = '0;
        case (w_judge)
            JUDGE_IDLE: ;
            JUDGE_WINDOW: begin
                w_hit_ok  = hit_lanes & w_head_mask;
                w_hit_bad = hit_lanes & ~w_head_mask;
            end
            default: w_hit_bad = hit_lanes;
        endcase
    end

    // Hits on the retiring row clear first, so only unstruck lanes count as missed.
    assign w_miss = w_pop ? (w_head_mask & ~w_hit_ok) : '0;

    // Lanes never overlap and a lane has one colour, so row precedence cannot change the pixel.
    always_comb begin : render_scan
        logic [Y_W+1:0] v_x;
        logic [Y_W+1:0] v_y;
        logic [Y_W+1:0] v_lo;
        logic [Y_W+1:0] v_row;
        logic [Y_W+1:0] v_h;
        w_lit   = 1'b0;
        w_color = FONDO;
        v_x     = {2'b00, presentX};
        v_y     = {2'b00, presentY};
        v_lo    = '0;
        v_row   = '0;
        v_h     = '0;
        for (int unsigned l = 0; l < N_LANES; l++) begin
            v_lo = (Y_W+2)'(X0 + l * PITCH);
            if (v_x > v_lo && v_x <= v_lo + (Y_W+2)'(LANE_W)) begin
                for (int unsigned r = 0; r < N_ROWS; r++) begin
                    v_row = {2'b00, w_ys[r]};
                    v_h   = v_row >> 3;
                    if (v_h > (Y_W+2)'(LANE_W)) v_h = (Y_W+2)'(LANE_W);
                    if (w_valid[r] && w_masks[r][l] && v_y > v_row && v_y <= v_row + v_h) begin
                        w_lit   = 1'b1;
                        w_color = lane_color(l);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hit_ok  <= '0;
            r_hit_bad <= '0;
            r_miss    <= '0;
            r_pixel   <= FONDO;
            r_pintar  <= 1'b0;
        end else if (enable) begin
            r_hit_ok  <= '0;
            r_hit_bad <= '0;
            r_miss    <= '0;
            r_pixel   <= FONDO;
            r_pintar  <= 1'b0;
        end else begin
            r_hit_ok  <= w_hit_ok;
            r_hit_bad <= w_hit_bad;
            r_miss    <= w_miss;
            r_pixel   <= (video_on && w_lit) ? w_color : FONDO;
            r_pintar  <= video_on && w_lit;
        end
    end

    assign hit_ok  = r_hit_ok;
    assign hit_bad = r_hit_bad;
    assign miss    = r_miss;
    assign pixel   = r_pixel;
    assign pintar  = r_pintar;

endmodule

// File: tb/tb_note_highway.sv
// Directed bench for note_highway with hand-computed expectations.
module tb_note_highway;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       frame_tick;
    logic       row_valid;
    logic [4:0] row_mask;
    logic       row_ready;
    logic       hit_strobe;
    logic [4:0] hit_lanes;
    logic [4:0] hit_ok;
    logic [4:0] hit_bad;
    logic [4:0] miss;
    logic       video_on;
    logic [9:0] presentX;
    logic [9:0] presentY;
    logic [7:0] pixel;
    logic       pintar;

    int n_checks = 0;
    int n_errors = 0;

    note_highway dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .frame_tick (frame_tick),
        .row_valid  (row_valid),
        .row_mask   (row_mask),
        .row_ready  (row_ready),
        .hit_strobe (hit_strobe),
        .hit_lanes  (hit_lanes),
        .hit_ok     (hit_ok),
        .hit_bad    (hit_bad),
        .miss       (miss),
        .video_on   (video_on),
        .presentX   (presentX),
        .presentY   (presentY),
        .pixel      (pixel),
        .pintar     (pintar)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        frame_tick = 1'b1;
        repeat (n) step();
        frame_tick = 1'b0;
    endtask

    task automatic push(input logic [4:0] m);
        row_valid = 1'b1;
        row_mask  = m;
        step();
        row_valid = 1'b0;
    endtask

    task automatic strike(input logic [4:0] lanes);
        hit_strobe = 1'b1;
        hit_lanes  = lanes;
        step();
        hit_strobe = 1'b0;
        hit_lanes  = '0;
    endtask

    task automatic flush();
        enable = 1'b1;
        step();
        enable = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ready_held;
        reset = 1'b1; enable = 1'b0; frame_tick = 1'b0; row_valid = 1'b0; row_mask = '0;
        hit_strobe = 1'b0; hit_lanes = '0; video_on = 1'b0; presentX = '0; presentY = '0;
        step(); step();
        check("rst_ready", row_ready, 1);
        check("rst_hit_ok", hit_ok, 0);
        check("rst_hit_bad", hit_bad, 0);
        check("rst_miss", miss, 0);
        check("rst_pixel", pixel, 255);
        check("rst_pintar", pintar, 0);
        reset = 1'b0;
        step();

        // 1: single row falls 480 px and retires with a miss
        push(5'b00001);
        ready_held = 1'b1;
        frame_tick = 1'b1;
        for (int i = 1; i <= 480; i++) begin
            step();
            if (row_ready !== 1'b1) ready_held = 1'b0;
            if (i == 479) check("t1_miss_early", miss, 0);
            if (i == 480) check("t1_miss_retire", miss, 5'b00001);
        end
        frame_tick = 1'b0;
        check("t1_ready_held", ready_held, 1);
        step();
        check("t1_miss_pulse", miss, 0);
        strike(5'b00001);
        check("t1_empty_after", hit_bad, 5'b00001);

        // 2: fill to capacity, ninth row waits for the first retire
        flush();
        for (int i = 0; i < 8; i++) begin
            push(5'(i + 1));
            if (i == 6) check("t2_ready_7", row_ready, 1);
        end
        check("t2_ready_full", row_ready, 0);
        row_valid = 1'b1;
        row_mask  = 5'b11111;
        frame_tick = 1'b1;
        repeat (479) step();
        check("t2_ready_479", row_ready, 0);
        step();
        frame_tick = 1'b0;
        check("t2_ready_retire", row_ready, 1);
        check("t2_miss_first", miss, 5'b00001);
        step();
        row_valid = 1'b0;
        check("t2_ninth_taken", row_ready, 0);
        flush();
        check("t2_ready_flush", row_ready, 1);

        // 3: partial hit in window, remainder missed at retire
        push(5'b10101);
        ticks(420);
        strike(5'b10011);
        check("t3_hit_ok", hit_ok, 5'b10001);
        check("t3_hit_bad", hit_bad, 5'b00010);
        ticks(59);
        check("t3_miss_early", miss, 0);
        ticks(1);
        check("t3_miss", miss, 5'b00100);

        // 4: window edges
        flush();
        push(5'b11111);
        ticks(399);
        strike(5'b00001);
        check("t4_399_bad", hit_bad, 5'b00001);
        check("t4_399_ok", hit_ok, 0);
        ticks(1);
        strike(5'b00010);
        check("t4_400_ok", hit_ok, 5'b00010);
        check("t4_400_bad", hit_bad, 0);
        ticks(40);
        strike(5'b00100);
        check("t4_440_ok", hit_ok, 5'b00100);
        ticks(1);
        strike(5'b01000);
        check("t4_441_bad", hit_bad, 5'b01000);
        check("t4_441_ok", hit_ok, 0);
        flush();
        strike(5'b10110);
        check("t4_empty_bad", hit_bad, 5'b10110);
        check("t4_empty_ok", hit_ok, 0);

        // 5: render lane 1 cube at y=100 (h=12)
        push(5'b00010);
        ticks(100);
        video_on = 1'b1; presentX = 10'd200; presentY = 10'd105;
        step();
        check("t5_pixel_in", pixel, 28);
        check("t5_pintar_in", pintar, 1);
        presentX = 10'd240; presentY = 10'd112;
        step();
        check("t5_pixel_corner", pixel, 28);
        presentX = 10'd200; presentY = 10'd113;
        step();
        check("t5_pixel_below", pixel, 255);
        check("t5_pintar_below", pintar, 0);
        presentX = 10'd176; presentY = 10'd105;
        step();
        check("t5_pixel_left", pixel, 255);
        presentX = 10'd200; video_on = 1'b0;
        step();
        check("t5_pixel_blank", pixel, 255);
        check("t5_pintar_blank", pintar, 0);

        // 6: async reset with three rows in flight
        flush();
        push(5'b00001);
        ticks(5);
        push(5'b00010);
        ticks(5);
        push(5'b00100);
        ticks(100);
        video_on = 1'b1; presentX = 10'd100; presentY = 10'd115;
        step();
        check("t6_pixel_pre", pixel, 224);
        #2 reset = 1'b1;
        #1;
        check("t6_pixel_async", pixel, 255);
        step();
        check("t6_ready", row_ready, 1);
        check("t6_miss", miss, 0);
        check("t6_pixel", pixel, 255);
        check("t6_pintar", pintar, 0);
        reset = 1'b0;
        step();
        check("t6_pixel_after", pixel, 255);
        strike(5'b00111);
        check("t6_empty_bad", hit_bad, 5'b00111);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
